spi_lcd_rx: RTL and testbench

//  SPI target-side receiver for the LCD command/data link, i.e. the far end of the SPI LCD master.

---
 rtl/spi_lcd_pkg.sv | 23 ++
 rtl/lcd_rx_fifo.sv | 53 +++++
 rtl/spi_lcd_rx.sv | 158 +++++++++++++++
 tb/tb_spi_lcd_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_pkg.sv
// Shared types and constants for the SPI LCD target receiver.
package spi_lcd_pkg;

   localparam int BYTE_W  = 8;
   localparam int ENTRY_W = BYTE_W + 1;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'b00,
      IDLE      = 2'b01,
      SHIFT     = 2'b10
   } rx_state_e;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic              tag,
      input logic [BYTE_W-1:0] data
   );
      return {tag, data};
   endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module lcd_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = empty ? '0 : mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q + AW'(push_ok);
      rd_d  = rd_q + AW'(pop_ok);
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI (mode 0) target receiver for the LCD link: byte deserialiser,
// dc tagging, FIFO buffering, sticky error flags and a byte counter.
module spi_lcd_rx
   import spi_lcd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              din,
   input  logic              dc,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_dc,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              ovf,
   output logic              frame_err,
   input  logic              clr_err,
   output logic [15:0]       byte_cnt
);

   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
   logic ss_prev_q, sck_prev_q;
   logic ss_s, sck_s, din_s, dc_s;
   logic sck_rise, ss_rise, ss_fall;

   rx_state_e         state_q, state_d;
   logic [BYTE_W-2:0] shreg_q, shreg_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              ovf_q, ovf_d;
   logic              frame_err_q, frame_err_d;
   logic [15:0]       byte_cnt_q, byte_cnt_d;

   logic               push;
   logic               frame_set;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head;
   logic               fifo_full, fifo_empty;
   logic               pop_ok, accept, drop;

   // Reset clears synchronisers to 0 so a held-low ss keeps us in WAIT_IDLE.
   always_comb begin
      ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], ss};
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
      din_sync_d = {din_sync_q[SYNC_STAGES-2:0], din};
      dc_sync_d  = {dc_sync_q[SYNC_STAGES-2:0], dc};
   end

   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign din_s    = din_sync_q[SYNC_STAGES-1];
   assign dc_s     = dc_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign ss_rise  = ss_s & ~ss_prev_q;
   assign ss_fall  = ~ss_s & ss_prev_q;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      push       = 1'b0;
      frame_set  = 1'b0;
      push_entry = pack_entry(dc_s, {shreg_q, din_s});
      unique case (state_q)
         WAIT_IDLE: begin
            if (ss_s) state_d = IDLE;
         end
         IDLE: begin
            if (ss_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               shreg_d   = {shreg_q[BYTE_W-3:0], din_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               push      = (bit_cnt_q == 3'd7);
            end
            // ss rise sees the count after any same-cycle sck_rise
            if (ss_rise) begin
               state_d   = IDLE;
               frame_set = (bit_cnt_d != '0);
               bit_cnt_d = '0;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   assign pop_ok = ~fifo_empty & rx_ready;
   assign accept = push & (~fifo_full | pop_ok);
   assign drop   = push & fifo_full & ~pop_ok;

   always_comb begin
      ovf_d       = drop | (ovf_q & ~clr_err);
      frame_err_d = frame_set | (frame_err_q & ~clr_err);
      byte_cnt_d  = byte_cnt_q + 16'(accept);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync_q   <= '0;
         sck_sync_q  <= '0;
         din_sync_q  <= '0;
         dc_sync_q   <= '0;
         ss_prev_q   <= 1'b0;
         sck_prev_q  <= 1'b0;
         state_q     <= WAIT_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         ovf_q       <= 1'b0;
         frame_err_q <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         ss_sync_q   <= ss_sync_d;
         sck_sync_q  <= sck_sync_d;
         din_sync_q  <= din_sync_d;
         dc_sync_q   <= dc_sync_d;
         ss_prev_q   <= ss_s;
         sck_prev_q  <= sck_s;
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         ovf_q       <= ovf_d;
         frame_err_q <= frame_err_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   lcd_rx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (rx_ready),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_valid  = ~fifo_empty;
   assign rx_dc     = head[ENTRY_W-1];
   assign rx_data   = head[BYTE_W-1:0];
   assign ovf       = ovf_q;
   assign frame_err = frame_err_q;
   assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: protocol-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_lcd_rx;

   localparam int DEPTH = 8;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst, ss, sck, din, dc, rx_ready, clr_err;
   logic [7:0]  rx_data;
   logic        rx_dc, rx_valid, ovf, frame_err;
   logic [15:0] byte_cnt;

   always #5 clk = ~clk;

   spi_lcd_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ss        (ss),
      .sck       (sck),
      .din       (din),
      .dc        (dc),
      .rx_data   (rx_data),
      .rx_dc     (rx_dc),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .ovf       (ovf),
      .frame_err (frame_err),
      .clr_err   (clr_err),
      .byte_cnt  (byte_cnt)
   );

   typedef enum {EV_SCK, EV_SSF, EV_SSR} ev_kind_e;
   typedef struct {
      int       stamp;
      ev_kind_e kind;
      logic     d;
      logic     c;
   } ev_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit started = 0;

   ev_t        evq[$];
   logic [8:0] mq[$];
   logic [8:0] got[$];
   logic       m_ovf = 0, m_fe = 0;
   logic [15:0] m_cnt = 0;
   int         m_st = 0;
   int         m_bits = 0;
   logic [7:0] m_sh = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [8:0] gv(input int i);
      if (i < got.size()) return got[i];
      return 9'h1ff;
   endfunction

   // Model: 0=await ss high, 1=idle, 2=in frame.
   always @(posedge clk) begin
      bit         pop, push, fe_set, ovf_set;
      logic [8:0] pe;
      ev_t        e;
      cyc++;
      pop = rx_ready && (mq.size() > 0);
      push = 0; fe_set = 0; ovf_set = 0; pe = '0;
      if (!rst && m_st == 0 && ss) m_st = 1;
      while (evq.size() > 0 && evq[0].stamp <= cyc) begin
         e = evq.pop_front();
         if (!rst) begin
            case (e.kind)
               EV_SCK: if (m_st == 2) begin
                  m_sh = {m_sh[6:0], e.d};
                  m_bits++;
                  if (m_bits == 8) begin
                     push = 1; pe = {e.c, m_sh}; m_bits = 0;
                  end
               end
               EV_SSF: if (m_st == 1) begin m_st = 2; m_bits = 0; end
               EV_SSR: begin
                  if (m_st == 2 && m_bits != 0) fe_set = 1;
                  m_bits = 0;
                  m_st = 1;
               end
               default: ;
            endcase
         end
      end
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_fe = 0; m_cnt = 0; m_st = 0; m_bits = 0;
      end else begin
         bit acc;
         acc = push && !(mq.size() == DEPTH && !pop);
         if (push && !acc) ovf_set = 1;
         if (pop) void'(mq.pop_front());
         if (acc) begin mq.push_back(pe); m_cnt++; end
         m_ovf = ovf_set | (m_ovf & !clr_err);
         m_fe  = fe_set | (m_fe & !clr_err);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("rx_valid", rx_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("rx_data", rx_data, mq[0][7:0]);
            chk("rx_dc", rx_dc, mq[0][8]);
         end
         chk("ovf", ovf, m_ovf);
         chk("frame_err", frame_err, m_fe);
         chk("byte_cnt", byte_cnt, m_cnt);
         if (rx_valid && rx_ready) got.push_back({rx_dc, rx_data});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #3; end
   endtask

   task automatic add_ev(input ev_kind_e k, input logic d, input logic c);
      ev_t e;
      e.stamp = cyc + LAT; e.kind = k; e.d = d; e.c = c;
      evq.push_back(e);
   endtask

   task automatic ss_fall();
      ss = 0; add_ev(EV_SSF, 0, 0); tick(8);
   endtask

   task automatic ss_rise();
      ss = 1; add_ev(EV_SSR, 0, 0); tick(8);
   endtask

   task automatic send_bit(input logic b, input logic c, input bit rdy, input bit clr);
      sck = 0; din = b; dc = c;
      tick(4);
      sck = 1; add_ev(EV_SCK, b, c);
      tick(2);
      if (rdy) rx_ready = 1;
      if (clr) clr_err = 1;
      tick(1);
      if (rdy) rx_ready = 0;
      if (clr) clr_err = 0;
      tick(1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic c,
                            input bit rdy = 0, input bit clr = 0);
      for (int i = 7; i >= 0; i--) send_bit(b[i], c, rdy && i == 0, clr && i == 0);
      sck = 0;
      tick(4);
   endtask

   task automatic pulse_clr();
      clr_err = 1; tick(1); clr_err = 0; tick(1);
   endtask

   task automatic do_reset();
      ss = 1; sck = 0; rst = 1; tick(2); rst = 0; tick(6);
   endtask

   task automatic drain();
      rx_ready = 1;
      for (int i = 0; i < 100 && mq.size() > 0; i++) tick(1);
      chk("drain_timeout", mq.size(), 0);
      rx_ready = 0;
      tick(2);
   endtask

   initial begin
      logic [7:0] b14;
      rst = 1; ss = 1; sck = 0; din = 0; dc = 0; rx_ready = 0; clr_err = 0;
      tick(3); rst = 0; tick(6);
      started = 1;
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_dc", rx_dc, 0);
      chk("rst_cnt", byte_cnt, 0);
      chk("rst_flags", {ovf, frame_err}, 0);

      // cmd then data with consumer ready
      rx_ready = 1; got.delete();
      ss_fall();
      send_byte(8'h21, 1'b0);
      send_byte(8'haa, 1'b1);
      ss_rise();
      rx_ready = 0; tick(4);
      chk("t1_n", got.size(), 2);
      chk("t1_e0", gv(0), 9'h021);
      chk("t1_e1", gv(1), 9'h1aa);
      chk("t1_cnt", byte_cnt, 2);
      chk("t1_flags", {ovf, frame_err}, 0);

      // overflow with nine bytes
      do_reset(); got.delete();
      ss_fall();
      for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
      ss_rise();
      chk("t2_valid", rx_valid, 1);
      chk("t2_head", rx_data, 8'h00);
      chk("t2_ovf", ovf, 1);
      chk("t2_cnt", byte_cnt, 8);
      drain();
      chk("t2_n", got.size(), 8);
      for (int i = 0; i < 8; i++) chk("t2_drain", gv(i), 9'h100 | 9'(i));

      // partial frame
      pulse_clr();
      chk("t3_clr", ovf, 0);
      ss_fall();
      send_bit(1, 1, 0, 0); send_bit(0, 1, 0, 0); send_bit(1, 1, 0, 0);
      send_bit(1, 1, 0, 0); send_bit(0, 1, 0, 0);
      sck = 0; tick(4);
      ss_rise();
      chk("t3_fe", frame_err, 1);
      chk("t3_cnt", byte_cnt, 8);
      chk("t3_nopush", rx_valid, 0);
      got.delete(); rx_ready = 1;
      ss_fall();
      send_byte(8'hc6, 1'b1);
      ss_rise();
      rx_ready = 0;
      chk("t3_n", got.size(), 1);
      chk("t3_c6", gv(0), 9'h1c6);
      chk("t3_cnt2", byte_cnt, 9);

      // reset mid-byte, bus stays low
      b14 = 8'h14;
      ss_fall();
      for (int i = 7; i >= 4; i--) send_bit(b14[i], 0, 0, 0);
      rst = 1; tick(1); rst = 0; tick(1);
      for (int i = 3; i >= 0; i--) send_bit(b14[i], 0, 0, 0);
      sck = 0; tick(4);
      chk("t4_nopush", rx_valid, 0);
      chk("t4_cnt", byte_cnt, 0);
      chk("t4_fe", frame_err, 0);
      ss_rise();
      got.delete(); rx_ready = 1;
      ss_fall();
      send_byte(8'h83, 1'b0);
      ss_rise();
      rx_ready = 0;
      chk("t4_n", got.size(), 1);
      chk("t4_83", gv(0), 9'h083);
      chk("t4_cnt2", byte_cnt, 1);

      // push and pop together while full
      ss_fall();
      for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b1);
      send_byte(8'h40, 1'b1, 1, 0);
      ss_rise();
      chk("t5_ovf", ovf, 0);
      chk("t5_cnt", byte_cnt, 10);
      chk("t5_head", rx_data, 8'h31);
      got.delete();
      drain();
      chk("t5_n", got.size(), 8);
      chk("t5_tail", gv(7), 9'h140);

      // clear versus simultaneous overflow
      ss_fall();
      for (int i = 0; i < 9; i++) send_byte(8'h50 + 8'(i), 1'b0);
      chk("t6_ovf", ovf, 1);
      pulse_clr();
      chk("t6_clr", ovf, 0);
      send_byte(8'h60, 1'b0, 0, 1);
      chk("t6_setwins", ovf, 1);
      ss_rise();
      chk("t6_cnt", byte_cnt, 18);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
